// File: rtl/permute_control_if.sv
// Valid/ready block handshake with a last-block marker.
// Used for both the absorb (load -> controller) and squeeze (controller -> dump) sides.
interface permute_control_if;
    logic valid;
    logic ready;
    logic last;

    modport master (output valid, output last, input ready);
    modport slave  (input valid, input last, output ready);
endinterface

// File: rtl/permute_control.sv
// Sequencing FSM for the Keccak permute datapath: absorb blocks, run rounds, squeeze blocks.
// Latency: 24 cycles from block accept (round 0 folded into the accept cycle) to dst valid.
// Backpressure: src ready only in IDLE/WAIT_BLOCK; FSM holds in SQUEEZE until dst ready.
module permute_control #(
    parameter int NUM_ROUNDS = 24
) (
    input  logic              clk,
    input  logic              rst,
    permute_control_if.slave  src,
    permute_control_if.master dst,
    output logic              busy,
    input  logic              round_start,
    input  logic              round_done,
    input  logic              last_output_block,
    output logic              copy_control_data,
    output logic              absorb_enable,
    output logic              round_en,
    output logic              round_count_load,
    output logic              output_size_count_en,
    output logic              state_reset
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PERM_ABSORB  = 3'd1,
        WAIT_BLOCK   = 3'd2,
        SQUEEZE      = 3'd3,
        PERM_SQUEEZE = 3'd4
    } state_t;

    // Round termination comes from the datapath counter; round_start is status only.
    localparam int unused_num_rounds = NUM_ROUNDS;
    logic unused_round_start;
    assign unused_round_start = round_start;

    state_t state;
    state_t state_nxt;
    logic   last_in_q;
    logic   last_in_nxt;
    logic   src_rdy;
    logic   dst_vld;
    logic   accept;
    logic   emit;

    // Ready is gated by reset so nothing is accepted while rst is low.
    assign src_rdy = rst & ((state == IDLE) | (state == WAIT_BLOCK));
    assign dst_vld = (state == SQUEEZE);
    assign accept  = src.valid & src_rdy;
    assign emit    = dst_vld & dst.ready;

    assign src.ready = src_rdy;
    assign dst.valid = dst_vld;
    assign dst.last  = dst_vld & last_output_block;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_in_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_in_q <= last_in_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_in_nxt = last_in_q;
        case (state)
            IDLE, WAIT_BLOCK: begin
                if (accept) begin
                    last_in_nxt = src.last;
                    state_nxt   = PERM_ABSORB;
                end
            end
            PERM_ABSORB: begin
                if (round_done) begin
                    state_nxt = last_in_q ? SQUEEZE : WAIT_BLOCK;
                end
            end
            SQUEEZE: begin
                if (emit) begin
                    state_nxt = last_output_block ? IDLE : PERM_SQUEEZE;
                end
            end
            PERM_SQUEEZE: begin
                if (round_done) begin
                    state_nxt = SQUEEZE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        copy_control_data    = 1'b0;
        absorb_enable        = 1'b0;
        round_en             = 1'b0;
        round_count_load     = 1'b0;
        output_size_count_en = 1'b0;
        state_reset          = 1'b0;
        case (state)
            IDLE: begin
                round_count_load = rst;
                state_reset      = ~rst | ~src.valid;
                if (accept) begin
                    copy_control_data = 1'b1;
                    absorb_enable     = 1'b1;
                    round_en          = 1'b1;
                end
            end
            PERM_ABSORB: begin
                round_en = 1'b1;
            end
            WAIT_BLOCK: begin
                // Mode and output size stay fixed for the whole message.
                if (accept) begin
                    absorb_enable = 1'b1;
                    round_en      = 1'b1;
                end
            end
            SQUEEZE: begin
                if (emit) begin
                    output_size_count_en = 1'b1;
                    round_en             = ~last_output_block;
                end
            end
            PERM_SQUEEZE: begin
                round_en = 1'b1;
            end
            default: begin
                state_reset = 1'b1;
            end
        endcase
    end

endmodule
